// File: rtl/serial_sub_n_if.sv
// rtl/serial_sub_n_if.sv - handshake and operand/result bundle for serial_sub_n
interface serial_sub_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, borrow_out, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, borrow_out, overflow
  );
endinterface

// File: rtl/serial_sub_n.sv
// rtl/serial_sub_n.sv - bit-serial WIDTH-bit add/subtract unit, LSB first
module serial_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_sub_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             mode_q, mode_d;
  logic             bw_q, bw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;

  logic             ai, bi, bit_v, bout;
  logic [WIDTH-1:0] sum_next;

  // State register plus all datapath flops; everything clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      mode_q   <= 1'b0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      bo_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      mode_q   <= mode_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      bo_q     <= bo_d;
      ov_q     <= ov_d;
    end
  end

  // Next state and the shared 1-bit adder/subtractor cell
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    mode_d   = mode_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bo_d     = bo_q;
    ov_d     = ov_q;

    ai       = a_sh_q[0];
    bi       = b_sh_q[0];
    bit_v    = ai ^ bi ^ bw_q;
    // Same flop carries the borrow (sub) or the carry (add)
    bout     = mode_q ? ((ai & bi) | (bw_q & (ai ^ bi)))
                      : ((~ai & bi) | (~(ai ^ bi) & bw_q));
    sum_next = {bit_v, sum_sh_q[WIDTH-1:1]};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // DONE accepts start as well, so back-to-back ops lose no cycle
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          mode_d  = bus.mode;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_next;
        bw_d     = bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Visible outputs only move here; overflow is carry-in vs carry-out of MSB
          result_d = sum_next;
          bo_d     = bout;
          ov_d     = bw_q ^ bout;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.borrow_out = bo_q;
  assign bus.overflow   = ov_q;
endmodule
